csp_channel: RTL and testbench
==============================

// Module: csp_channel
// PURPOSE
// - Synthesizable one-place CSP channel: 4-phase bundled-data (P4PhaseBD) handshake between one sender and one receiver.
// - Replaces the behavioural Channel used between memory, memory interface and NoC (read/write/T/row/col/data links).
// - Decouples the two sides by buffering exactly one WIDTH-bit token.
// - Reports occupancy, transfer count and sticky protocol errors.
// PARAMETERS
// - WIDTH        8  token width in bits; the sender zero-extends narrower values, and upper bits of wider values are dropped.
// - SYNC_STAGES  0  synchronizer flops on the inbound snd_req/rcv_ack (0 = inputs already synchronous; legal 0..3).
// - CNT_W        32 width of xfer_count.
// PORTS
// - clk        in   1      single clock; all state updates on its rising edge.
// - rst_n      in   1      asynchronous active-low reset.
// - snd_req    in   1      sender request; snd_data is valid and stable while high.
// - snd_data   in   WIDTH  sender token.
// - snd_ack    out  1      channel acknowledge to the sender.
// - rcv_req    out  1      channel request to the receiver; rcv_data is valid while high.
// - rcv_data   out  WIDTH  buffered token.
// - rcv_ack    in   1      receiver acknowledge.
// - full       out  1      buffer holds an undelivered token.
// - xfer_count out  CNT_W  completed receive handshakes; wraps modulo 2**CNT_W.
// - proto_err  out  1      sticky protocol-violation flag.
// BEHAVIOUR
// - Reset (async assert, sync deassert): snd_ack=0, rcv_req=0, rcv_data=0, full=0, xfer_count=0, proto_err=0, both FSMs idle.
// - Reset mid-handshake aborts the handshake and discards the buffered token.
// - "sampled" means after SYNC_STAGES flops. Latencies below assume SYNC_STAGES=0; each stage adds one cycle per input.
// - Send FSM, S_IDLE (snd_ack=0):
//   - On sampled snd_req=1 with full=0: capture snd_data, set full, go to S_ACK.
//   - snd_ack rises on the same edge, i.e. one cycle after req is seen.
//   - If full=1, hold snd_ack low; the sender stalls with req high.
// - Send FSM, S_ACK (snd_ack=1): wait for sampled snd_req=0, then drop snd_ack and return to S_IDLE.
// - Receive FSM, R_IDLE (rcv_req=0): when full=1, raise rcv_req and go to R_REQ.
// - Receive FSM, R_REQ: on sampled rcv_ack=1, drop rcv_req and go to R_RTZ.
// - Receive FSM, R_RTZ: on sampled rcv_ack=0, clear full, increment xfer_count and go to R_IDLE.
// - Freeing the buffer and capturing a new token never happen on the same edge.
//   - Capture requires the registered full=0, so a new capture occurs one cycle after the clear at the earliest.
// - rcv_data changes only at capture; it is stable throughout R_REQ and R_RTZ.
// - The send side may complete its return-to-zero while the receive side is still active; this is the decoupling.
// - Minimum cycle per token (SYNC_STAGES=0): six clocks when both peers respond in one cycle.
// - proto_err is set (cleared only by reset) on any of:
//   - sampled snd_req falls while in S_IDLE after being high the previous cycle (request withdrawn before ack);
//   - snd_data changes while snd_req=1 and snd_ack=0 in S_IDLE with full=0 (bundled data unstable);
//   - sampled rcv_ack=1 while in R_IDLE.
//   - Detecting an error does not alter the FSMs.
// STRUCTURE
// - Shared package csp_pkg:
//   - typedef enum hs_protocol_e {P4PhaseBD, P2PhaseBD, P4PhaseDR}; only P4PhaseBD is legal here, and an elaboration-time assertion rejects others.
//   - send/receive state enums; default WIDTH constant.
// - Sub-module csp_sync (SYNC_STAGES-deep flop chain, async reset to 0), instantiated for snd_req and rcv_ack.
// - Datapath: one WIDTH-bit register plus full flag; two independent FSMs; counter; error logic.
// TESTING
// - Reset: hold rst_n=0, drive snd_req=1 -> snd_ack=0, rcv_req=0, full=0, xfer_count=0, proto_err=0.
// - Single token: send 8'h18, receiver acks one cycle after rcv_req.
//   - Expect rcv_data=8'h18, xfer_count=1, proto_err=0.
//   - Expect snd_ack high exactly one cycle after snd_req rises.
// - Back-pressure: send 8'h05 with receiver silent, then send 8'h09.
//   - Second snd_ack stays 0 and rcv_data stays 8'h05 until the first receive completes.
//   - Then 8'h09 is delivered; xfer_count=2.
// - Stream 25 tokens 0..24 with random peer delays 0-5 cycles.
//   - Order and values are preserved, xfer_count=25, no proto_err.
// - Errors:
//   - drop snd_req before snd_ack -> proto_err=1;
//   - reset, then raise rcv_ack with rcv_req=0 -> proto_err=1;
//   - proto_err stays 1 across later legal transfers.
// - Reset mid-transfer while rcv_req=1 -> outputs return to reset values asynchronously; the next token transfers normally.

Source files
------------

// File: rtl/csp_pkg.sv
// Shared types and constants for the one-place CSP channel.
package csp_pkg;

  // Handshake protocols known to the channel family; only P4PhaseBD is built here.
  typedef enum logic [1:0] {P4PhaseBD, P2PhaseBD, P4PhaseDR} hs_protocol_e;

  // Send side: S_IDLE waits for a request, S_ACK waits for the return-to-zero.
  typedef enum logic {S_IDLE, S_ACK} send_state_e;

  // Receive side: R_IDLE waits for a token, R_REQ waits for ack, R_RTZ waits for ack release.
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_RTZ} recv_state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/csp_sync.sv
// Flop chain for bringing an asynchronous handshake wire into clk.
// Only instantiated with STAGES >= 1.
module csp_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the input through STAGES flops; reset clears the chain to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/csp_channel.sv
// One-place CSP channel, 4-phase bundled data, with occupancy, transfer count
// and sticky protocol-error reporting.
//   state  | meaning
//   S_IDLE | snd_ack low, waiting for a request while the buffer is free
//   S_ACK  | token captured, snd_ack high, waiting for snd_req to fall
//   R_IDLE | rcv_req low, waiting for the buffer to fill
//   R_REQ  | rcv_req high, waiting for rcv_ack
//   R_RTZ  | rcv_req low again, waiting for rcv_ack to fall before freeing
module csp_channel
  import csp_pkg::*;
#(
  parameter int unsigned  WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned  SYNC_STAGES = 0,
  parameter int unsigned  CNT_W       = 32,
  parameter hs_protocol_e PROTOCOL    = P4PhaseBD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             snd_req,
  input  logic [WIDTH-1:0] snd_data,
  output logic             snd_ack,
  output logic             rcv_req,
  output logic [WIDTH-1:0] rcv_data,
  input  logic             rcv_ack,
  output logic             full,
  output logic [CNT_W-1:0] xfer_count,
  output logic             proto_err
);

  if (PROTOCOL != P4PhaseBD) begin : g_bad_protocol
    $error("csp_channel: only P4PhaseBD handshake is implemented");
  end
  if (SYNC_STAGES > 3) begin : g_bad_sync
    $error("csp_channel: SYNC_STAGES must be 0..3");
  end

  logic        req_s;
  logic        ack_s;
  send_state_e s_state;
  recv_state_e r_state;
  logic        req_s_prev;
  logic        req_raw_prev;
  logic [WIDTH-1:0] data_prev;
  logic        capture;
  logic        release_buf;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign req_s = snd_req;
    assign ack_s = rcv_ack;
  end else begin : g_sync
    csp_sync #(.STAGES(SYNC_STAGES)) u_sync_req (
      .clk(clk), .rst_n(rst_n), .d(snd_req), .q(req_s)
    );
    csp_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (
      .clk(clk), .rst_n(rst_n), .d(rcv_ack), .q(ack_s)
    );
  end

  // Capture uses registered full, so it can never coincide with the release edge.
  assign capture     = (s_state == S_IDLE) && req_s && !full;
  assign release_buf = (r_state == R_RTZ) && !ack_s;

  // Send FSM: acknowledge on capture, drop ack once the request returns to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_state <= S_IDLE;
      snd_ack <= 1'b0;
    end else begin
      case (s_state)
        S_IDLE: if (capture) begin
          s_state <= S_ACK;
          snd_ack <= 1'b1;
        end
        S_ACK: if (!req_s) begin
          s_state <= S_IDLE;
          snd_ack <= 1'b0;
        end
        default: begin
          s_state <= S_IDLE;
          snd_ack <= 1'b0;
        end
      endcase
    end
  end

  // Token buffer and occupancy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcv_data <= '0;
      full     <= 1'b0;
    end else if (capture) begin
      rcv_data <= snd_data;
      full     <= 1'b1;
    end else if (release_buf) begin
      full     <= 1'b0;
    end
  end

  // Receive FSM: offer the token, then free it and count after the ack returns to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= R_IDLE;
      rcv_req    <= 1'b0;
      xfer_count <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (full) begin
          r_state <= R_REQ;
          rcv_req <= 1'b1;
        end
        R_REQ: if (ack_s) begin
          r_state <= R_RTZ;
          rcv_req <= 1'b0;
        end
        R_RTZ: if (!ack_s) begin
          r_state    <= R_IDLE;
          xfer_count <= xfer_count + CNT_W'(1);
        end
        default: begin
          r_state <= R_IDLE;
          rcv_req <= 1'b0;
        end
      endcase
    end
  end

  // Sticky protocol-violation detection; observes only, never steers the FSMs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_s_prev   <= 1'b0;
      req_raw_prev <= 1'b0;
      data_prev    <= '0;
      proto_err    <= 1'b0;
    end else begin
      req_s_prev   <= req_s;
      req_raw_prev <= snd_req;
      data_prev    <= snd_data;
      if ((s_state == S_IDLE) && req_s_prev && !req_s)
        proto_err <= 1'b1;
      if ((s_state == S_IDLE) && !full && snd_req && req_raw_prev && (snd_data != data_prev))
        proto_err <= 1'b1;
      if ((r_state == R_IDLE) && ack_s)
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_csp_channel.sv
// Randomized scoreboard bench for csp_channel (WIDTH=8, SYNC_STAGES=0).
module tb_csp_channel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        snd_req;
  logic [7:0]  snd_data;
  logic        snd_ack;
  logic        rcv_req;
  logic [7:0]  rcv_data;
  logic        rcv_ack;
  logic        full;
  logic [31:0] xfer_count;
  logic        proto_err;

  csp_channel #(.WIDTH(8), .SYNC_STAGES(0), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .snd_req(snd_req), .snd_data(snd_data), .snd_ack(snd_ack),
    .rcv_req(rcv_req), .rcv_data(rcv_data), .rcv_ack(rcv_ack),
    .full(full), .xfer_count(xfer_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  int  model_xfers = 0;
  bit  rcv_auto    = 1'b0;
  bit  rcv_busy    = 1'b0;
  int  rcv_max     = 0;
  bit  bp_done;
  int  lat;
  int  lat2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: each new offer to the receiver must carry the oldest outstanding token.
  logic prev_rcv_req = 1'b0;
  always @(negedge clk) begin
    if (rcv_req && !prev_rcv_req) begin
      if (exp_q.size() == 0) check("unexpected_offer", 32'(rcv_data), 32'hdead);
      else check("rcv_data_order", 32'(rcv_data), 32'(exp_q.pop_front()));
    end
    prev_rcv_req = rcv_req;
  end

  // Receiver peer: random-delay 4-phase acknowledge when enabled.
  always begin
    int d;
    int n;
    @(negedge clk);
    if (rcv_auto && rcv_req && rst_n) begin
      rcv_busy = 1'b1;
      d = $urandom_range(rcv_max, 0);
      repeat (d) @(posedge clk);
      @(posedge clk); #1 rcv_ack = 1'b1;
      n = 0;
      while (n < 50) begin
        @(negedge clk); n++;
        if (!rcv_req) break;
      end
      check("rcv_req_drop", 32'(rcv_req), 32'h0);
      d = $urandom_range(rcv_max, 0);
      repeat (d) @(posedge clk);
      @(posedge clk); #1 rcv_ack = 1'b0;
      model_xfers++;
      rcv_busy = 1'b0;
    end
  end

  task automatic send(input logic [7:0] v, input int pre, output int latency);
    int n;
    repeat (pre) @(posedge clk);
    @(posedge clk); #1;
    snd_data = v;
    snd_req  = 1'b1;
    exp_q.push_back(v);
    latency = 0;
    while (latency < 300) begin
      @(posedge clk); #1; latency++;
      if (snd_ack) break;
    end
    check("snd_ack_rise", 32'(snd_ack), 32'h1);
    snd_req = 1'b0;
    n = 0;
    while (n < 50 && snd_ack) begin
      @(posedge clk); #1; n++;
    end
    check("snd_ack_fall", 32'(snd_ack), 32'h0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 300) begin
      @(negedge clk); n++;
      if (!full && !rcv_req && !rcv_ack && !snd_ack && !rcv_busy) break;
    end
    check("idle_reached", 32'(full | rcv_req | rcv_busy), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    model_xfers = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; snd_req = 1'b1; snd_data = 8'h00; rcv_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_snd_ack",   32'(snd_ack), 32'h0);
    check("rst_rcv_req",   32'(rcv_req), 32'h0);
    check("rst_full",      32'(full),    32'h0);
    check("rst_xfer",      xfer_count,   32'h0);
    check("rst_proto_err", 32'(proto_err), 32'h0);
    check("rst_rcv_data",  32'(rcv_data), 32'h0);
    snd_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Single token, receiver responds in one cycle.
    rcv_max = 0; rcv_auto = 1'b1;
    send(8'h18, 0, lat);
    check("single_ack_latency", 32'(lat), 32'd1);
    wait_idle();
    check("single_rcv_data",  32'(rcv_data), 32'h18);
    check("single_xfer",      xfer_count, 32'(model_xfers));
    check("single_xfer_abs",  xfer_count, 32'd1);
    check("single_proto_err", 32'(proto_err), 32'h0);

    // Back-pressure: receiver silent while a second token waits.
    rcv_auto = 1'b0;
    send(8'h05, 0, lat);
    check("bp_first_latency", 32'(lat), 32'd1);
    bp_done = 1'b0;
    fork
      begin send(8'h09, 0, lat2); bp_done = 1'b1; end
    join_none
    begin
      bit held = 1'b1;
      repeat (12) begin
        @(negedge clk);
        if (snd_ack !== 1'b0 || rcv_data !== 8'h05 || full !== 1'b1) held = 1'b0;
      end
      check("bp_hold", 32'(held), 32'h1);
    end
    rcv_auto = 1'b1;
    begin
      int n = 0;
      while (!bp_done && n < 300) begin @(negedge clk); n++; end
      check("bp_second_done", 32'(bp_done), 32'h1);
    end
    wait_idle();
    check("bp_rcv_data", 32'(rcv_data), 32'h09);
    check("bp_xfer",     xfer_count, 32'd3);

    // Stream 0..24 with random peer delays.
    rcv_max = 5;
    for (int i = 0; i < 25; i++) send(8'(i), $urandom_range(5, 0), lat);
    wait_idle();
    check("stream_xfer",      xfer_count, 32'(model_xfers));
    check("stream_xfer_abs",  xfer_count, 32'd28);
    check("stream_q_empty",   32'(exp_q.size()), 32'h0);
    check("stream_proto_err", 32'(proto_err), 32'h0);

    // Request withdrawn before acknowledge while the buffer is occupied.
    rcv_auto = 1'b0; rcv_max = 0;
    send(8'h42, 0, lat);
    @(posedge clk); #1 snd_data = 8'h43; snd_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 snd_req = 1'b0;
    @(negedge clk); @(negedge clk);
    check("err_withdraw", 32'(proto_err), 32'h1);
    rcv_auto = 1'b1;
    wait_idle();
    check("err_withdraw_xfer", xfer_count, 32'(model_xfers));

    // Reset clears the flag; an ack in R_IDLE sets it again.
    do_reset();
    check("err_cleared", 32'(proto_err), 32'h0);
    rcv_auto = 1'b0;
    @(posedge clk); #1 rcv_ack = 1'b1;
    @(posedge clk); #1 rcv_ack = 1'b0;
    @(negedge clk);
    check("err_ack_idle", 32'(proto_err), 32'h1);
    rcv_auto = 1'b1; rcv_max = 3;
    send(8'h77, 1, lat);
    send(8'h88, 0, lat);
    wait_idle();
    check("err_sticky",      32'(proto_err), 32'h1);
    check("err_sticky_xfer", xfer_count, 32'd2);

    // Asynchronous reset in the middle of a receive handshake.
    do_reset();
    rcv_auto = 1'b0;
    send(8'h3c, 0, lat);
    begin
      int n = 0;
      while (!rcv_req && n < 20) begin @(negedge clk); n++; end
      check("mid_rcv_req_up", 32'(rcv_req), 32'h1);
    end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("mid_rst_rcv_req",  32'(rcv_req),  32'h0);
    check("mid_rst_full",     32'(full),     32'h0);
    check("mid_rst_rcv_data", 32'(rcv_data), 32'h0);
    check("mid_rst_snd_ack",  32'(snd_ack),  32'h0);
    check("mid_rst_xfer",     xfer_count,    32'h0);
    exp_q.delete();
    model_xfers = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rcv_auto = 1'b1; rcv_max = 0;
    send(8'ha5, 0, lat);
    check("post_rst_latency", 32'(lat), 32'd1);
    wait_idle();
    check("post_rst_data",  32'(rcv_data), 32'ha5);
    check("post_rst_xfer",  xfer_count, 32'd1);
    check("post_rst_err",   32'(proto_err), 32'h0);
    check("post_rst_q",     32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
